// File: rtl/oci_dct_pkg.sv
// Shared widths, atom encodings and packer state type for the OCI DCT trace packer.
package oci_dct_pkg;
  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = ATOM_W * SLOTS;
  localparam int CNT_W  = 4;

  localparam logic [ATOM_W-1:0] ATOM_NULL = 2'b00;
  localparam logic [ATOM_W-1:0] ATOM_NT   = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_T    = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_EXC  = 2'b11;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PARTIAL = 2'b01,
    PENDING = 2'b10
  } dct_state_e;
endpackage

// File: rtl/niosii_system_nios2_0_oci_dct_frame_reg.sv
// Output holding register for closed trace frames, with valid/ready handshake.
module oci_dct_frame_reg
  import oci_dct_pkg::*;
#(
  parameter int FW = BUF_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [FW-1:0] load_data,
  input  logic [CW-1:0] load_count,
  input  logic          frm_ready,
  output logic          slot_free,
  output logic          frm_valid,
  output logic [FW-1:0] frm_data,
  output logic [CW-1:0] frm_count
);
  logic          valid_r;
  logic [FW-1:0] data_r;
  logic [CW-1:0] count_r;

  assign slot_free = !valid_r || frm_ready;
  assign frm_valid = valid_r;
  assign frm_data  = data_r;
  assign frm_count = count_r;

  // Frame slot: a load takes priority over the consumer draining it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      count_r <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      count_r <= load_count;
    end else if (frm_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end
endmodule

// File: rtl/niosii_system_nios2_0_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 15-slot frames and sequences them to the trace FIFO.
module niosii_system_nios2_0_oci_dct_packer
  import oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             trace_enable,
  input  logic             atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic             atom_ready,
  input  logic             flush,
  output logic             frm_valid,
  output logic [BUF_W-1:0] frm_data,
  output logic [CNT_W-1:0] frm_count,
  input  logic             frm_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             overflow,
  input  logic             overflow_clr
);
  dct_state_e       state_r, state_s;
  logic [BUF_W-1:0] buf_r, buf_s, fill_buf_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, fill_cnt_s;
  logic             overflow_r;
  logic             slot_free_s, load_s, close_s, accept_s;

  assign atom_ready = trace_enable && (state_r != PENDING);
  assign accept_s   = atom_valid && atom_ready;
  assign dct_buffer = buf_r;
  assign dct_count  = cnt_r;
  assign overflow   = overflow_r;

  // Buffer contents after folding in this cycle's atom; nulls are consumed without storage.
  always_comb begin
    fill_buf_s = buf_r;
    fill_cnt_s = cnt_r;
    if (accept_s && (atom_data != ATOM_NULL)) begin
      fill_buf_s = buf_r | ({{(BUF_W-ATOM_W){1'b0}}, atom_data} << {cnt_r, 1'b0});
      fill_cnt_s = cnt_r + 4'd1;
    end else begin
      fill_buf_s = buf_r;
      fill_cnt_s = cnt_r;
    end
    close_s = (fill_cnt_s == 4'd15) ||
              ((flush || !trace_enable) && (fill_cnt_s != 4'd0));
  end

  // Next-state: a closed frame either moves to the output slot or waits in PENDING.
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    case (state_r)
      PENDING: begin
        if (slot_free_s) begin
          load_s  = 1'b1;
          state_s = EMPTY;
          buf_s   = '0;
          cnt_s   = 4'd0;
        end else begin
          state_s = PENDING;
        end
      end
      EMPTY, PARTIAL: begin
        if (close_s && slot_free_s) begin
          load_s  = 1'b1;
          state_s = EMPTY;
          buf_s   = '0;
          cnt_s   = 4'd0;
        end else if (close_s) begin
          state_s = PENDING;
          buf_s   = fill_buf_s;
          cnt_s   = fill_cnt_s;
        end else begin
          buf_s   = fill_buf_s;
          cnt_s   = fill_cnt_s;
          state_s = (fill_cnt_s == 4'd0) ? EMPTY : PARTIAL;
        end
      end
      default: begin
        state_s = EMPTY;
        buf_s   = '0;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Packer state and buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
      buf_r   <= '0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;
      cnt_r   <= cnt_s;
    end
  end

  // Sticky loss flag; a new loss outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (atom_valid && trace_enable && !atom_ready) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  oci_dct_frame_reg #(.FW(BUF_W), .CW(CNT_W)) u_frame_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .load_data  (buf_s == buf_s ? (state_r == PENDING ? buf_r : fill_buf_s) : fill_buf_s),
    .load_count (state_r == PENDING ? cnt_r : fill_cnt_s),
    .frm_ready  (frm_ready),
    .slot_free  (slot_free_s),
    .frm_valid  (frm_valid),
    .frm_data   (frm_data),
    .frm_count  (frm_count)
  );
endmodule

// File: tb/tb_niosii_system_nios2_0_oci_dct_packer.sv
// Randomised and directed bench for the DCT packer against a queue-based frame model.
module tb_niosii_system_nios2_0_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset, trace_enable, atom_valid, flush, frm_ready, overflow_clr;
  logic [1:0]  atom_data;
  logic        atom_ready, frm_valid, overflow;
  logic [29:0] frm_data, dct_buffer;
  logic [3:0]  frm_count, dct_count;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // model: atoms waiting in the buffer, plus the output slot contents
  int          m_q[$];
  bit          m_pending, m_fv, m_ovf;
  logic [29:0] m_fd;
  logic [3:0]  m_fc;

  niosii_system_nios2_0_oci_dct_packer dut (
    .clk(clk), .reset(reset), .trace_enable(trace_enable), .atom_valid(atom_valid),
    .atom_data(atom_data), .atom_ready(atom_ready), .flush(flush), .frm_valid(frm_valid),
    .frm_data(frm_data), .frm_count(frm_count), .frm_ready(frm_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] model_buf();
    logic [29:0] b = 30'd0;
    foreach (m_q[i]) b = b | (30'(m_q[i]) << (2 * i));
    return b;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as atom lists, advanced once per rising edge.
  always @(posedge clk) begin
    bit free, rdy, load;
    free = !m_fv || frm_ready;
    load = 1'b0;
    if (reset) begin
      m_q.delete(); m_pending = 0; m_fv = 0; m_ovf = 0; m_fd = 30'd0; m_fc = 4'd0;
      chk_en = 1'b1;
    end else begin
      rdy = trace_enable && !m_pending;
      if (atom_valid && trace_enable && !rdy) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      if (m_pending) begin
        load = free;
      end else begin
        if (atom_valid && rdy && atom_data != 2'b00) m_q.push_back(int'(atom_data));
        if (m_q.size() == 15 || ((flush || !trace_enable) && m_q.size() > 0)) begin
          if (free) load = 1'b1;
          else m_pending = 1;
        end
      end
      if (load) begin
        m_fd = model_buf(); m_fc = 4'(m_q.size()); m_fv = 1;
        m_q.delete(); m_pending = 0;
      end else if (frm_ready) begin
        m_fv = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("atom_ready", {31'd0, atom_ready}, {31'd0, trace_enable && !m_pending});
      cmp("frm_valid",  {31'd0, frm_valid},  {31'd0, m_fv});
      cmp("frm_data",   {2'd0, frm_data},    {2'd0, m_fd});
      cmp("frm_count",  {28'd0, frm_count},  {28'd0, m_fc});
      cmp("dct_buffer", {2'd0, dct_buffer},  {2'd0, model_buf()});
      cmp("dct_count",  {28'd0, dct_count},  32'(m_q.size()));
      cmp("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
    end
  end

  task automatic step(input logic v, input logic [1:0] d, input logic fl);
    atom_valid = v; atom_data = d; flush = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; trace_enable = 1'b1; atom_valid = 1'b0; atom_data = 2'b00;
    flush = 1'b0; frm_ready = 1'b1; overflow_clr = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    cmp("reset_frm_valid", {31'd0, frm_valid}, 32'd0);
    cmp("reset_dct_count", {28'd0, dct_count}, 32'd0);
    reset = 1'b0;

    // 15 taken atoms, slot free
    for (int i = 0; i < 15; i++) begin
      cmp("full_ready", {31'd0, atom_ready}, 32'd1);
      step(1'b1, 2'b10, 1'b0);
    end
    cmp("full_valid", {31'd0, frm_valid}, 32'd1);
    cmp("full_data",  {2'd0, frm_data},   32'h2AAAAAAA);
    cmp("full_count", {28'd0, frm_count}, 32'd15);

    // 01,10,11 then flush
    step(1'b1, 2'b01, 1'b0); step(1'b1, 2'b10, 1'b0); step(1'b1, 2'b11, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    cmp("flush_count", {28'd0, frm_count}, 32'd3);
    cmp("flush_data",  {2'd0, frm_data},   32'h00000039);
    cmp("flush_dct0",  {28'd0, dct_count}, 32'd0);
    step(1'b0, 2'b00, 1'b0);

    // back-pressure: frame 1 held, frame 2 pending
    frm_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 2'b01, 1'b0);
    cmp("pend_ready", {31'd0, atom_ready}, 32'd0);
    cmp("pend_hold",  {2'd0, frm_data},    32'h2AAAAAAA);
    cmp("pend_buf",   {2'd0, dct_buffer},  32'h15555555);
    step(1'b1, 2'b10, 1'b0);
    cmp("pend_ovf", {31'd0, overflow}, 32'd1);
    frm_ready = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    cmp("pend_f2_valid", {31'd0, frm_valid}, 32'd1);
    cmp("pend_f2_data",  {2'd0, frm_data},   32'h15555555);
    step(1'b0, 2'b00, 1'b0);
    overflow_clr = 1'b1; step(1'b0, 2'b00, 1'b0); overflow_clr = 1'b0;
    cmp("ovf_clr", {31'd0, overflow}, 32'd0);

    // nulls interleaved with 5 taken atoms
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b00, 1'b0); step(1'b1, 2'b10, 1'b0);
    end
    step(1'b0, 2'b00, 1'b1);
    cmp("null_count", {28'd0, frm_count}, 32'd5);
    cmp("null_data",  {2'd0, frm_data},   32'h000002AA);

    // trace disable closes a 7-atom frame, later atoms ignored
    for (int i = 0; i < 7; i++) step(1'b1, 2'b11, 1'b0);
    trace_enable = 1'b0;
    step(1'b1, 2'b11, 1'b0);
    cmp("dis_count", {28'd0, frm_count}, 32'd7);
    cmp("dis_data",  {2'd0, frm_data},   32'h00003FFF);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 1'b0);
    cmp("dis_ovf", {31'd0, overflow},  32'd0);
    cmp("dis_cnt", {28'd0, dct_count}, 32'd0);
    trace_enable = 1'b1;

    // reset with a held frame and 9 atoms pending
    frm_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    cmp("rst_pend_cnt", {28'd0, dct_count}, 32'd9);
    reset = 1'b1; step(1'b0, 2'b00, 1'b0); reset = 1'b0;
    cmp("rst_valid", {31'd0, frm_valid}, 32'd0);
    cmp("rst_data",  {2'd0, frm_data},   32'd0);
    cmp("rst_buf",   {2'd0, dct_buffer}, 32'd0);
    frm_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);
    cmp("rst_no_frame", {31'd0, frm_valid}, 32'd0);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      trace_enable = ($urandom % 16) != 0;
      frm_ready    = ($urandom % 3) != 0;
      overflow_clr = ($urandom % 50) == 0;
      reset        = ($urandom % 600) == 0;
      step(($urandom % 4) != 0, 2'($urandom), ($urandom % 20) == 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
